// File: rtl/conv1d_pkg.sv
// conv1d_pkg: shared constants and FSM state type for the 1-D convolution result path
package conv1d_pkg;
    localparam int PSUM_WIDTH_DEF = 16;
    localparam int SAT_LIMIT = 255;
    typedef enum logic [1:0] {IDLE, CAPTURE, DONE} state_t;
endpackage

// File: rtl/out_bram.sv
// out_bram: simple dual-port read-first RAM, one write port and one registered read port
module out_bram #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 16,
    parameter int AW = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             we,
    input  logic [AW-1:0]    waddr,
    input  logic [WIDTH-1:0] wdata,
    input  logic             re,
    input  logic [AW-1:0]    raddr,
    output logic [WIDTH-1:0] rdata
);
    logic [WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk)
        if (we) mem[waddr] <= wdata;

    // only the read register is reset; array contents survive reset
    always_ff @(posedge clk or posedge rst)
        if (rst) rdata <= '0;
        else if (re) rdata <= mem[raddr];
endmodule

// File: rtl/psum_bram_writer.sv
// psum_bram_writer: captures one frame of array psums into an output BRAM with host readback
// Optional PSUM_SAT_EN: store min(psum_in >> SAT_SHIFT, 255) instead of the raw psum.
module psum_bram_writer import conv1d_pkg::*; #(
    parameter int PSUM_WIDTH = PSUM_WIDTH_DEF,
    parameter int ADDR_WIDTH = 4,
    parameter int NUM_OUT    = 5,
    parameter int SAT_SHIFT  = 0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic                  valid_in,
    input  logic [PSUM_WIDTH-1:0] psum_in,
    input  logic                  rd_en,
    input  logic [ADDR_WIDTH-1:0] rd_addr,
    output logic [PSUM_WIDTH-1:0] rd_data,
    output logic                  rd_valid,
    output logic                  busy,
    output logic                  done,
    output logic [ADDR_WIDTH:0]   count,
    output logic                  drop_err
);
    localparam logic [ADDR_WIDTH:0] N = (ADDR_WIDTH+1)'(NUM_OUT);

    if (NUM_OUT < 1 || NUM_OUT > 2**ADDR_WIDTH || SAT_SHIFT < 0 || SAT_SHIFT >= PSUM_WIDTH) begin : g_bad_param
        $error("psum_bram_writer: NUM_OUT or SAT_SHIFT out of range");
    end

    state_t state, next_state;
    logic cap_we, rd_oor;
    logic [PSUM_WIDTH-1:0] wdata, bram_q;

    // start wins over valid_in, so a coincident psum is never written
    assign cap_we = valid_in && !start && state == CAPTURE;

`ifdef PSUM_SAT_EN
    logic [PSUM_WIDTH-1:0] shifted;
    assign shifted = psum_in >> SAT_SHIFT;
    assign wdata = shifted > PSUM_WIDTH'(SAT_LIMIT) ? PSUM_WIDTH'(SAT_LIMIT) : shifted;
`else
    assign wdata = psum_in;
`endif

    always_comb begin
        next_state = state;
        if (start) next_state = CAPTURE;
        else if (cap_we && count + 1'b1 == N) next_state = DONE;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            busy     <= 1'b0;
            done     <= 1'b0;
            count    <= '0;
            drop_err <= 1'b0;
            rd_valid <= 1'b0;
            rd_oor   <= 1'b0;
        end else begin
            state    <= next_state;
            busy     <= next_state == CAPTURE;
            done     <= next_state == DONE;
            count    <= start ? '0 : cap_we ? count + 1'b1 : count;
            drop_err <= start ? valid_in : drop_err | (valid_in && state != CAPTURE);
            rd_valid <= rd_en;
            if (rd_en) rd_oor <= {1'b0, rd_addr} >= N;
        end
    end

    out_bram #(.WIDTH(PSUM_WIDTH), .DEPTH(2**ADDR_WIDTH), .AW(ADDR_WIDTH)) u_bram (
        .clk   (clk),
        .rst   (rst),
        .we    (cap_we),
        .waddr (count[ADDR_WIDTH-1:0]),
        .wdata (wdata),
        .re    (rd_en),
        .raddr (rd_addr),
        .rdata (bram_q)
    );

    // out-of-frame addresses read as zero; flag is held alongside the BRAM register
    assign rd_data = rd_oor ? '0 : bram_q;
endmodule

// File: tb/tb_psum_bram_writer.sv
// tb_psum_bram_writer: scoreboard bench for psum_bram_writer (also run with PSUM_SAT_EN)
module tb_psum_bram_writer;
    logic        clk = 0, rst = 1, start = 0, valid_in = 0, rd_en = 0;
    logic [15:0] psum_in = 0;
    logic [3:0]  rd_addr = 0;
    logic [15:0] rd_data;
    logic        rd_valid, busy, done, drop_err;
    logic [4:0]  count;
    logic [15:0] exp_q[$];
    int vecs = 0, errs = 0;

    psum_bram_writer #(.PSUM_WIDTH(16), .ADDR_WIDTH(4), .NUM_OUT(5), .SAT_SHIFT(2)) dut (
        .clk(clk), .rst(rst), .start(start), .valid_in(valid_in), .psum_in(psum_in),
        .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data), .rd_valid(rd_valid),
        .busy(busy), .done(done), .count(count), .drop_err(drop_err)
    );

    always #5 clk = ~clk;

    function automatic logic [15:0] store(input int p);
`ifdef PSUM_SAT_EN
        int s = p >> 2;
        return 16'(s > 255 ? 255 : s);
`else
        return 16'(p);
`endif
    endfunction

    // scoreboard: every read request pushes its expectation, every rd_valid pops one
    always @(negedge clk) begin
        if (rd_valid) begin
            vecs++;
            if (exp_q.size() == 0) begin
                errs++;
                $display("FAIL rd_unexpected: rd_valid with nothing pending, rd_data=%0d", rd_data);
            end else begin
                logic [15:0] e;
                e = exp_q.pop_front();
                if (rd_data !== e) begin
                    errs++;
                    $display("FAIL rd_data: got %0d expected %0d", rd_data, e);
                end
            end
        end
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic send(input int p);
        valid_in = 1;
        psum_in = 16'(p);
        tick();
        valid_in = 0;
    endtask

    task automatic rd(input int a, input logic [15:0] e);
        rd_en = 1;
        rd_addr = 4'(a);
        exp_q.push_back(e);
        tick();
        rd_en = 0;
        vecs++;
        if (rd_valid !== 1'b1) begin
            errs++;
            $display("FAIL rd_valid: got %b expected 1 at addr %0d", rd_valid, a);
        end
    endtask

    task automatic pulse_start;
        start = 1;
        tick();
        start = 0;
    endtask

    task automatic check_outs(input string tag, input logic [4:0] c, input logic d, input logic b, input logic de);
        vecs++;
        if (count !== c || done !== d || busy !== b || drop_err !== de) begin
            errs++;
            $display("FAIL %s: count/done/busy/drop_err got %0d/%b/%b/%b expected %0d/%b/%b/%b",
                     tag, count, done, busy, drop_err, c, d, b, de);
        end
    endtask

    task automatic test_reset;
        rst = 1;
        tick();
        tick();
        vecs++;
        if ({count, done, busy, drop_err, rd_valid, rd_data} !== 25'd0) begin
            errs++;
            $display("FAIL reset: got count=%0d done=%b busy=%b drop_err=%b rd_valid=%b rd_data=%0d expected all 0",
                     count, done, busy, drop_err, rd_valid, rd_data);
        end
        rst = 0;
        tick();
    endtask

    task automatic test_back_to_back;
        pulse_start();
        check_outs("start", 0, 0, 1, 0);
        for (int i = 0; i < 5; i++) begin
            send(14 + 6 * i);
            check_outs("capture", 5'(i + 1), i == 4, i != 4, 0);
        end
        for (int i = 0; i < 5; i++) rd(i, store(14 + 6 * i));
        tick();
        vecs++;
        if (rd_valid !== 1'b0 || rd_data !== store(38)) begin
            errs++;
            $display("FAIL rd_hold: got valid=%b data=%0d expected 0/%0d", rd_valid, rd_data, store(38));
        end
    endtask

    task automatic test_drop;
        send(99);
        check_outs("drop_done", 5, 1, 0, 1);
        rd(4, store(38));
        pulse_start();
        check_outs("drop_clear", 0, 0, 1, 0);
    endtask

    task automatic test_read_first;
        send(14);
        send(20);
        valid_in = 1;
        psum_in = 50;
        rd_en = 1;
        rd_addr = 2;
        exp_q.push_back(store(26));
        tick();
        valid_in = 0;
        exp_q.push_back(store(50));
        tick();
        rd_addr = 7;
        exp_q.push_back(16'd0);
        tick();
        rd_en = 0;
        check_outs("rfw", 3, 0, 1, 0);
        vecs++;
        if (rd_valid !== 1'b1) begin
            errs++;
            $display("FAIL rd_oor_valid: got %b expected 1", rd_valid);
        end
    endtask

    task automatic test_restart;
        pulse_start();
        send(7);
        send(8);
        pulse_start();
        check_outs("restart", 0, 0, 1, 0);
        for (int i = 1; i <= 5; i++) send(i);
        check_outs("restart_done", 5, 1, 0, 0);
        for (int i = 0; i < 5; i++) rd(i, store(i + 1));
        start = 1;
        valid_in = 1;
        psum_in = 77;
        tick();
        start = 0;
        valid_in = 0;
        check_outs("start_valid", 0, 0, 1, 1);
    endtask

    task automatic test_rst_midframe;
        pulse_start();
        send(11);
        send(12);
        send(13);
        rd_en = 1;
        rd_addr = 1;
        tick();
        rd_en = 0;
        exp_q.push_back(store(12));
        #3 rst = 1;
        #1;
        vecs++;
        if ({count, done, busy, drop_err, rd_valid, rd_data} !== 25'd0) begin
            errs++;
            $display("FAIL rst_mid: got count=%0d done=%b busy=%b drop_err=%b rd_valid=%b rd_data=%0d expected all 0",
                     count, done, busy, drop_err, rd_valid, rd_data);
        end
        void'(exp_q.pop_back());
        tick();
        rst = 0;
        for (int i = 0; i < 3; i++) rd(i, store(11 + i));
        send(99);
        check_outs("drop_idle", 0, 0, 0, 1);
        rd(0, store(11));
    endtask

`ifdef PSUM_SAT_EN
    task automatic test_sat;
        pulse_start();
        send(38);
        send(16'h1234);
        rd(0, 16'd9);
        rd(1, 16'd255);
    endtask
`endif

    initial begin
        #100000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_back_to_back();
        test_drop();
        test_read_first();
        test_restart();
        test_rst_midframe();
`ifdef PSUM_SAT_EN
        test_sat();
`endif
        tick();
        tick();
        vecs++;
        if (exp_q.size() != 0) begin
            errs++;
            $display("FAIL rd_missing: %0d reads still pending, expected 0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end
endmodule

// File: doc/psum_bram_writer.md
# psum_bram_writer

Result-side sink for the 1-D systolic convolution array. It consumes the `valid_out`/`psum_out` stream the array produces and writes one frame of partial sums into an internal output BRAM at consecutive addresses. It reports frame completion and lets the host read results back through a synchronous read port. It is the write-side counterpart of the input BRAMs that feed the array.

## Interface
Parameters:
- `PSUM_WIDTH`, 16: width of the incoming partial sum and of each stored word.
- `ADDR_WIDTH`, 4: output BRAM address width, giving 2**ADDR_WIDTH words.
- `NUM_OUT`, 5: results per frame. Must satisfy 1 ≤ NUM_OUT ≤ 2**ADDR_WIDTH. The default covers 7 inputs with 3 taps.
- `SAT_SHIFT`, 0: right shift applied before saturation. Used only when `PSUM_SAT_EN` is defined.

Ports:
- `clk`  in  1  single clock; all logic is rising-edge.
- `rst`  in  1  asynchronous, active-high reset.
- `start`  in  1  one-cycle pulse that arms capture of a new frame.
- `valid_in`  in  1  psum strobe, driven by the array's `valid_out`.
- `psum_in`  in  PSUM_WIDTH  partial sum, driven by the array's `psum_out`.
- `rd_en`  in  1  readback request.
- `rd_addr`  in  ADDR_WIDTH  readback address.
- `rd_data`  out  PSUM_WIDTH  readback word.
- `rd_valid`  out  1  `rd_data` is valid for this cycle.
- `busy`  out  1  high while in CAPTURE.
- `done`  out  1  frame complete; level output.
- `count`  out  ADDR_WIDTH+1  number of results written in the current frame.
- `drop_err`  out  1  sticky flag: a psum arrived while the block was not capturing.

## Operation
- The FSM has three states:
  - IDLE: `start` moves to CAPTURE and clears `count`, `done` and `drop_err`.
  - CAPTURE: each `valid_in` writes `psum_in` to `mem[count]`, then `count` increments. When the write makes `count` equal NUM_OUT, the FSM moves to DONE.
  - DONE: holds `done=1`. `start` moves to CAPTURE with the same clearing as in IDLE.
- `start` during CAPTURE restarts the frame: `count` returns to 0 and stored words are not erased.
- `valid_in` in IDLE or DONE is discarded and sets `drop_err`. Memory and `count` are unchanged.
- `start` and `valid_in` in the same cycle, in any state: the state change happens and the psum is discarded. `drop_err` is set in the new frame.
- Readback is allowed in every state, and `rd_data` is read-first. A read of the address being written in the same cycle returns the old word.
- `rd_addr` ≥ NUM_OUT returns 0, with `rd_valid` still asserted.
- No arithmetic without the macro: words are stored verbatim.

## Timing
- Reset values: state IDLE, `count=0`, `done=0`, `busy=0`, `drop_err=0`, `rd_valid=0`, `rd_data=0`. BRAM contents are not reset.
- Write: a `valid_in` sampled at edge N updates the memory and `count` at edge N.
- `done` and `busy` are registered from the state. The edge that writes the NUM_OUT-th word also sets `done=1` and clears `busy`, so `done=1` becomes visible in the same cycle that `count==NUM_OUT` does.
- `busy` rises one cycle after `start` is sampled.
- Read: `rd_en` sampled at edge N gives `rd_data` and `rd_valid=1` after edge N, for one cycle. `rd_data` then holds its value while `rd_valid` returns to 0.
- No backpressure: the block accepts one psum per cycle, back-to-back, indefinitely.
- Reset during CAPTURE immediately forces IDLE and zeroes all outputs. Partial frame data stays in memory.

## Configuration
- `PSUM_SAT_EN` defined: the stored word is `min(psum_in >> SAT_SHIFT, 255)`, zero-extended to PSUM_WIDTH. This re-quantises results to 8 bits for the next layer.
- `PSUM_SAT_EN` undefined: words are stored unmodified and `SAT_SHIFT` is ignored.

## Structure
- Package `conv1d_pkg` holds:
  - the `PSUM_WIDTH` default constant;
  - the FSM state typedef (IDLE, CAPTURE, DONE);
  - the saturation limit constant (255).
- Sub-module `out_bram`: a simple dual-port, read-first RAM with one write port and one registered read port, parameterised by width and depth.
- FSM, counter and saturation logic live in the top module.

## Test plan
- Reset, `start`, then five back-to-back psums 14, 20, 26, 32, 38 → `count` steps 1 to 5, `done=1` on the cycle after the fifth edge, `busy` low. Reading addresses 0–4 returns 14, 20, 26, 32, 38, each one cycle after `rd_en`.
- `valid_in` with psum 99 while in IDLE → `drop_err=1`, `count=0`, memory unchanged. A following `start` clears `drop_err`.
- `start` after two of the five psums, then five new psums 1–5 → `done` after the fifth new psum. Addresses 0–4 read back 1–5.
- Assert `rst` mid-frame after three psums → all outputs at reset values in the same cycle, state IDLE. Readback of addresses 0–2 still returns the three stored values.
- Read address 7 with NUM_OUT=5 → `rd_data=0`, `rd_valid=1`. Read address 2 in the cycle it is written with 50 (old value 26) → returns 26; the next read returns 50.
- With `PSUM_SAT_EN` and `SAT_SHIFT=2`: psum 38 → stored 9; psum 0x1234 → stored 255.
